// File: rtl/wb_pkg.sv
// Shared write-back types and constants: load width encodings, the MEM/WB register layout
// and the load-data extraction/extension helper.
package wb_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            misalign;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } mem_wb_t;

  typedef struct packed {
    logic            misalign;
    logic [XLEN-1:0] data;
  } load_res_t;

  // Unknown widths are flagged as misaligned so the write is suppressed downstream.
  function automatic load_res_t load_extend(input logic [2:0]      funct3,
                                            input logic [1:0]      addr,
                                            input logic [XLEN-1:0] lmd);
    load_res_t  res;
    logic [7:0]  byteVal;
    logic [15:0] halfVal;
    res     = '0;
    byteVal = lmd[{addr, 3'b000} +: 8];
    halfVal = addr[1] ? lmd[31:16] : lmd[15:0];
    case (funct3)
      F3_LB:  res.data = {{(XLEN-8){byteVal[7]}}, byteVal};
      F3_LBU: res.data = {{(XLEN-8){1'b0}}, byteVal};
      F3_LH: begin
        res.data     = {{(XLEN-16){halfVal[15]}}, halfVal};
        res.misalign = addr[0];
      end
      F3_LHU: begin
        res.data     = {{(XLEN-16){1'b0}}, halfVal};
        res.misalign = addr[0];
      end
      F3_LW: begin
        res.data     = lmd;
        res.misalign = (addr != 2'b00);
      end
      default: res.misalign = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_stage_regfile.sv
// Integer register file: one synchronous write port, two asynchronous read ports with
// write-through bypass, x0 hardwired to zero.
module regfile_2r1w #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            reset,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr1_i,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk_i) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Bypass lets decode see the value being written back in this very cycle.
  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    if (raddr1_i == '0) begin
      rdata1_o = '0;
    end else if (we_i && (waddr_i == raddr1_i)) begin
      rdata1_o = wdata_i;
    end
  end

  always_comb begin
    rdata2_o = regs_q[raddr2_i];
    if (raddr2_i == '0) begin
      rdata2_o = '0;
    end else if (we_i && (waddr_i == raddr2_i)) begin
      rdata2_o = wdata_i;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register with load extension ahead of it, register
// file write/bypass, and the 64-bit retired-instruction counter.
module wb_stage
  import wb_pkg::*;
(
  input  logic            clk_i,
  input  logic            reset,
  input  logic            mem_valid_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            mem_reg_write_i,
  input  logic            mem_is_load_i,
  input  logic [2:0]      mem_funct3_i,
  input  logic [AW-1:0]   mem_rd_i,
  input  logic [XLEN-1:0] mem_alu_out_i,
  input  logic [XLEN-1:0] mem_lmd_i,
  input  logic [AW-1:0]   rs1_addr_i,
  input  logic [AW-1:0]   rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic            wb_valid_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            load_misalign_o,
  output logic [63:0]     instret_o
);

  mem_wb_t   memWb_q, memWb_d;
  load_res_t ldRes;
  logic      retire;
  logic [63:0] instret_q, instret_d;

  assign ldRes = load_extend(mem_funct3_i, mem_alu_out_i[1:0], mem_lmd_i);

  // Flush wins over stall; a misalign flag is only meaningful for a valid load.
  always_comb begin
    memWb_d = memWb_q;
    if (flush_i) begin
      memWb_d.valid    = 1'b0;
      memWb_d.misalign = 1'b0;
    end else if (!stall_i) begin
      memWb_d.valid     = mem_valid_i;
      memWb_d.reg_write = mem_reg_write_i;
      memWb_d.misalign  = mem_valid_i & mem_is_load_i & ldRes.misalign;
      memWb_d.rd        = mem_rd_i;
      memWb_d.data      = mem_is_load_i ? ldRes.data : mem_alu_out_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      memWb_q <= '0;
    end else begin
      memWb_q <= memWb_d;
    end
  end

  // An instruction retires on the edge it leaves WB, so stalled cycles never count.
  assign retire    = memWb_q.valid & ~memWb_q.misalign & ~stall_i & ~flush_i;
  assign instret_d = instret_q + {63'd0, retire};

  always_ff @(posedge clk_i) begin
    if (reset) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign wb_valid_o      = memWb_q.valid;
  assign wb_rd_o         = memWb_q.rd;
  assign wb_data_o       = memWb_q.data;
  assign load_misalign_o = memWb_q.misalign;
  assign wb_we_o         = memWb_q.valid & memWb_q.reg_write & ~memWb_q.misalign
                           & (memWb_q.rd != '0);
  assign instret_o       = instret_q;

  regfile_2r1w #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) uRegfile (
    .clk_i    (clk_i),
    .reset    (reset),
    .we_i     (wb_we_o),
    .waddr_i  (memWb_q.rd),
    .wdata_i  (memWb_q.data),
    .raddr1_i (rs1_addr_i),
    .raddr2_i (rs2_addr_i),
    .rdata1_o (rs1_data_o),
    .rdata2_o (rs2_data_o)
  );

endmodule
